// File: rtl/ras_ctrl_if.sv
// Signal bundle between ras_ctrl and its environment: fetch/decode requesters,
// the RAS instance, and the prediction/flush outputs. Slave is the controller's view.
`timescale 1ns/1ps
interface ras_ctrl_if #(
    parameter int unsigned ENTRIES_NUM = 4,
    parameter int unsigned ADDR_W      = 32
);
    localparam int unsigned DepthW = $clog2(ENTRIES_NUM + 1);

    logic              flush;
    logic              f_valid;
    logic              f_ready;
    logic              f_call;
    logic              f_ret;
    logic [ADDR_W-1:0] f_pc;
    logic              d_valid;
    logic              d_call;
    logic              d_ret;
    logic [ADDR_W-1:0] d_pc;
    logic              ras_top_valid;
    logic [ADDR_W-1:0] ras_top_data;
    logic              ras_push_req;
    logic              ras_pop_req;
    logic [ADDR_W-1:0] ras_push_data;
    logic              ras_flush;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_target;
    logic [DepthW-1:0] depth;

    modport master (
        output flush, f_valid, f_call, f_ret, f_pc,
        output d_valid, d_call, d_ret, d_pc,
        output ras_top_valid, ras_top_data,
        input  f_ready, ras_push_req, ras_pop_req, ras_push_data, ras_flush,
        input  pred_valid, pred_target, depth
    );

    modport slave (
        input  flush, f_valid, f_call, f_ret, f_pc,
        input  d_valid, d_call, d_ret, d_pc,
        input  ras_top_valid, ras_top_data,
        output f_ready, ras_push_req, ras_pop_req, ras_push_data, ras_flush,
        output pred_valid, pred_target, depth
    );
endinterface

// File: rtl/ras_ctrl.sv
// RAS front-end: arbitrates decode/fetch call-ret hints into one push/pop per cycle,
// tracks speculative depth, blocks underflow pops and predicts return targets.
`timescale 1ns/1ps
module ras_ctrl #(
    parameter int unsigned ENTRIES_NUM = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RA_OFFSET   = 8
) (
    input  logic        clk,
    input  logic        rst,
    ras_ctrl_if.slave   bus
);
    localparam int unsigned DepthW = $clog2(ENTRIES_NUM + 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(ENTRIES_NUM);
    localparam logic [ADDR_W-1:0] RaOff    = ADDR_W'(RA_OFFSET);

    typedef struct packed {
        logic              valid;
        logic              call;
        logic              ret;
        logic [ADDR_W-1:0] pc;
    } skid_t;

    skid_t             skid_q, skid_d;
    logic [DepthW-1:0] depth_q, depth_d;

    logic              kill;
    logic              f_ready;
    logic              f_hs;
    logic              d_act;
    logic              op_valid;
    logic              op_call;
    logic              op_ret;
    logic [ADDR_W-1:0] op_pc;
    logic              push;
    logic              pop;
    logic              depth_nz;
    logic [ADDR_W-1:0] d_push_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q  <= '0;
            depth_q <= '0;
        end else begin
            skid_q  <= skid_d;
            depth_q <= depth_d;
        end
    end

    // Next-state: arbitration (decode > skid > new fetch) and depth tracking
    always_comb begin
        kill        = rst | bus.flush;
        f_ready     = !skid_q.valid && !kill;
        f_hs        = bus.f_valid && f_ready;
        d_act       = bus.d_valid && !kill;
        depth_nz    = (depth_q != '0);
        d_push_data = bus.d_pc + RaOff;

        op_valid = 1'b0;
        op_call  = 1'b0;
        op_ret   = 1'b0;
        op_pc    = '0;
        skid_d   = skid_q;

        if (kill) begin
            skid_d = '0;
        end else if (d_act) begin
            op_valid = 1'b1;
            op_call  = bus.d_call;
            op_ret   = bus.d_ret;
            op_pc    = bus.d_pc;
            if (f_hs) begin
                skid_d = '{valid: 1'b1, call: bus.f_call, ret: bus.f_ret, pc: bus.f_pc};
            end
        end else if (skid_q.valid) begin
            op_valid     = 1'b1;
            op_call      = skid_q.call;
            op_ret       = skid_q.ret;
            op_pc        = skid_q.pc;
            skid_d.valid = 1'b0;
        end else if (f_hs) begin
            op_valid = 1'b1;
            op_call  = bus.f_call;
            op_ret   = bus.f_ret;
            op_pc    = bus.f_pc;
        end

        push = op_valid && op_call;
        // A pop against an empty speculative stack is dropped, never issued
        pop  = op_valid && op_ret && depth_nz;

        depth_d = depth_q;
        if (kill) begin
            depth_d = '0;
        end else if (push && pop) begin
            depth_d = depth_q;
        end else if (push) begin
            depth_d = (depth_q == DepthMax) ? DepthMax : depth_q + 1'b1;
        end else if (pop) begin
            depth_d = depth_q - 1'b1;
        end
    end

    // Outputs
    always_comb begin
        bus.f_ready       = f_ready;
        bus.ras_push_req  = push;
        bus.ras_pop_req   = pop;
        bus.ras_push_data = push ? (op_pc + RaOff) : '0;
        bus.ras_flush     = bus.flush && !rst;
        bus.depth         = rst ? '0 : depth_q;
        bus.pred_valid    = 1'b0;
        bus.pred_target   = '0;
        if (f_hs && bus.f_ret) begin
            // A same-cycle decode op overrides what the RAS top currently shows
            if (d_act && bus.d_call) begin
                bus.pred_valid  = 1'b1;
                bus.pred_target = d_push_data;
            end else if (d_act && bus.d_ret) begin
                bus.pred_valid  = 1'b0;
            end else begin
                bus.pred_valid  = bus.ras_top_valid && depth_nz;
                bus.pred_target = bus.ras_top_data;
            end
        end
    end
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl; inputs change on the falling edge,
// combinational outputs are sampled 1ns later and registered state a cycle later.
`timescale 1ns/1ps
module tb_ras_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ras_ctrl_if #(.ENTRIES_NUM(4), .ADDR_W(32)) bus ();

    ras_ctrl #(.ENTRIES_NUM(4), .ADDR_W(32), .RA_OFFSET(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle();
        bus.flush = 0; bus.f_valid = 0; bus.f_call = 0; bus.f_ret = 0; bus.f_pc = '0;
        bus.d_valid = 0; bus.d_call = 0; bus.d_ret = 0; bus.d_pc = '0;
        bus.ras_top_valid = 0; bus.ras_top_data = '0;
    endtask

    task automatic fetch(input logic call, input logic ret, input logic [31:0] pc);
        bus.f_valid = 1; bus.f_call = call; bus.f_ret = ret; bus.f_pc = pc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; idle();
        bus.flush = 1; fetch(1, 0, 32'h10); bus.d_valid = 1; bus.d_call = 1;
        #1;
        checks++; if (bus.f_ready !== 1'b0) begin errors++; $display("FAIL rst_f_ready got %0h want 0", bus.f_ready); end
        checks++; if (bus.ras_push_req !== 1'b0 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL rst_push_pop got %0b%0b want 00", bus.ras_push_req, bus.ras_pop_req); end
        checks++; if (bus.ras_flush !== 1'b0) begin errors++; $display("FAIL rst_ras_flush got %0h want 0", bus.ras_flush); end
        checks++; if (bus.depth !== 3'd0 || bus.pred_valid !== 1'b0) begin errors++; $display("FAIL rst_depth_pred got %0d/%0b want 0/0", bus.depth, bus.pred_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 0; idle();
        #1;
        checks++; if (bus.f_ready !== 1'b1 || bus.depth !== 3'd0) begin errors++; $display("FAIL post_rst got ready=%0b depth=%0d want 1/0", bus.f_ready, bus.depth); end
    endtask

    task automatic test_call_ret();
        @(negedge clk);
        idle(); fetch(1, 0, 32'h8000_0100);
        #1;
        checks++; if (bus.ras_push_req !== 1'b1 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL call_req got %0b%0b want 10", bus.ras_push_req, bus.ras_pop_req); end
        checks++; if (bus.ras_push_data !== 32'h8000_0108) begin errors++; $display("FAIL call_data got %h want 80000108", bus.ras_push_data); end
        @(negedge clk);
        checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL call_depth got %0d want 1", bus.depth); end
        idle(); fetch(0, 1, 32'h8000_0200);
        bus.ras_top_valid = 1; bus.ras_top_data = 32'h8000_0108;
        #1;
        checks++; if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h8000_0108) begin errors++; $display("FAIL ret_pred got %0b/%h want 1/80000108", bus.pred_valid, bus.pred_target); end
        checks++; if (bus.ras_pop_req !== 1'b1 || bus.ras_push_req !== 1'b0) begin errors++; $display("FAIL ret_req got pop=%0b push=%0b want 1/0", bus.ras_pop_req, bus.ras_push_req); end
        @(negedge clk);
        checks++; if (bus.depth !== 3'd0) begin errors++; $display("FAIL ret_depth got %0d want 0", bus.depth); end
        idle();
    endtask

    task automatic test_underflow();
        @(negedge clk);
        idle(); fetch(0, 1, 32'h40);
        bus.ras_top_valid = 1; bus.ras_top_data = 32'hdead_beef;
        #1;
        checks++; if (bus.pred_valid !== 1'b0 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL uflow got pred=%0b pop=%0b want 0/0", bus.pred_valid, bus.ras_pop_req); end
        checks++; if (bus.f_ready !== 1'b1) begin errors++; $display("FAIL uflow_ready got %0b want 1", bus.f_ready); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.depth !== 3'd0 || bus.f_ready !== 1'b1) begin errors++; $display("FAIL uflow_after got depth=%0d ready=%0b want 0/1", bus.depth, bus.f_ready); end
    endtask

    task automatic test_decode_skid();
        @(negedge clk);
        idle(); fetch(0, 1, 32'h500);
        bus.d_valid = 1; bus.d_call = 1; bus.d_pc = 32'h1000;
        #1;
        checks++; if (bus.ras_push_req !== 1'b1 || bus.ras_push_data !== 32'h1008 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL dcall got push=%0b data=%h pop=%0b want 1/1008/0", bus.ras_push_req, bus.ras_push_data, bus.ras_pop_req); end
        checks++; if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h1008) begin errors++; $display("FAIL dcall_pred got %0b/%h want 1/1008", bus.pred_valid, bus.pred_target); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.f_ready !== 1'b0 || bus.ras_pop_req !== 1'b1 || bus.ras_push_req !== 1'b0) begin errors++; $display("FAIL skid_pop got ready=%0b pop=%0b push=%0b want 0/1/0", bus.f_ready, bus.ras_pop_req, bus.ras_push_req); end
        checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL skid_depth got %0d want 1", bus.depth); end
        @(negedge clk);
        #1;
        checks++; if (bus.f_ready !== 1'b1 || bus.depth !== 3'd0 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL skid_done got ready=%0b depth=%0d pop=%0b want 1/0/0", bus.f_ready, bus.depth, bus.ras_pop_req); end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            idle(); fetch(1, 0, 32'(i * 256));
            #1;
            checks++; if (bus.ras_push_req !== 1'b1 || bus.ras_push_data !== 32'(i * 256 + 8)) begin errors++; $display("FAIL sat_push%0d got %0b/%h want 1/%h", i, bus.ras_push_req, bus.ras_push_data, 32'(i * 256 + 8)); end
            @(negedge clk);
            idle();
            checks++; if (bus.depth !== 3'((i > 4) ? 4 : i)) begin errors++; $display("FAIL sat_depth%0d got %0d want %0d", i, bus.depth, (i > 4) ? 4 : i); end
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            idle(); fetch(0, 1, 32'h900);
            bus.ras_top_valid = 1; bus.ras_top_data = 32'h0000_0a08;
            #1;
            checks++; if (bus.ras_pop_req !== (k <= 4) || bus.pred_valid !== (k <= 4)) begin errors++; $display("FAIL sat_ret%0d got pop=%0b pred=%0b want %0b", k, bus.ras_pop_req, bus.pred_valid, k <= 4); end
            @(negedge clk);
            idle();
            checks++; if (bus.depth !== 3'((k >= 4) ? 0 : 4 - k)) begin errors++; $display("FAIL sat_rdepth%0d got %0d want %0d", k, bus.depth, (k >= 4) ? 0 : 4 - k); end
        end
    endtask

    task automatic test_flush_skid();
        @(negedge clk);
        idle(); fetch(1, 0, 32'h5000);
        bus.d_valid = 1; bus.d_call = 1; bus.d_pc = 32'h4000;
        #1;
        checks++; if (bus.ras_push_data !== 32'h4008) begin errors++; $display("FAIL fl_dpush got %h want 4008", bus.ras_push_data); end
        @(negedge clk);
        idle(); bus.flush = 1;
        bus.d_valid = 1; bus.d_ret = 1; bus.d_pc = 32'h6000;
        #1;
        checks++; if (bus.ras_flush !== 1'b1 || bus.f_ready !== 1'b0) begin errors++; $display("FAIL fl_out got flush=%0b ready=%0b want 1/0", bus.ras_flush, bus.f_ready); end
        checks++; if (bus.ras_push_req !== 1'b0 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL fl_noop got push=%0b pop=%0b want 0/0", bus.ras_push_req, bus.ras_pop_req); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.depth !== 3'd0 || bus.f_ready !== 1'b1 || bus.ras_flush !== 1'b0) begin errors++; $display("FAIL fl_after got depth=%0d ready=%0b flush=%0b want 0/1/0", bus.depth, bus.f_ready, bus.ras_flush); end
        checks++; if (bus.ras_push_req !== 1'b0 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL fl_stale got push=%0b pop=%0b want 0/0", bus.ras_push_req, bus.ras_pop_req); end
    endtask

    task automatic test_wrap_and_replace();
        @(negedge clk);
        idle(); fetch(1, 0, 32'hffff_fffc);
        #1;
        checks++; if (bus.ras_push_data !== 32'h0000_0004) begin errors++; $display("FAIL wrap_data got %h want 00000004", bus.ras_push_data); end
        @(negedge clk);
        idle(); fetch(1, 0, 32'h1800);
        @(negedge clk);
        checks++; if (bus.depth !== 3'd2) begin errors++; $display("FAIL repl_pre got %0d want 2", bus.depth); end
        idle(); fetch(1, 1, 32'h2000);
        bus.ras_top_valid = 1; bus.ras_top_data = 32'h3000;
        #1;
        checks++; if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h3000) begin errors++; $display("FAIL repl_pred got %0b/%h want 1/3000", bus.pred_valid, bus.pred_target); end
        checks++; if (bus.ras_push_req !== 1'b1 || bus.ras_pop_req !== 1'b1 || bus.ras_push_data !== 32'h2008) begin errors++; $display("FAIL repl_req got %0b%0b/%h want 11/2008", bus.ras_push_req, bus.ras_pop_req, bus.ras_push_data); end
        @(negedge clk);
        idle();
        checks++; if (bus.depth !== 3'd2) begin errors++; $display("FAIL repl_depth got %0d want 2", bus.depth); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle(); fetch(0, 1, 32'h700);
        bus.d_valid = 1; bus.d_ret = 1; bus.d_pc = 32'h680;
        bus.ras_top_valid = 1; bus.ras_top_data = 32'h3000;
        #1;
        checks++; if (bus.pred_valid !== 1'b0 || bus.ras_pop_req !== 1'b1 || bus.ras_push_req !== 1'b0) begin errors++; $display("FAIL dret got pred=%0b pop=%0b push=%0b want 0/1/0", bus.pred_valid, bus.ras_pop_req, bus.ras_push_req); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.ras_pop_req !== 1'b1 || bus.depth !== 3'd1 || bus.f_ready !== 1'b0) begin errors++; $display("FAIL dret_skid got pop=%0b depth=%0d ready=%0b want 1/1/0", bus.ras_pop_req, bus.depth, bus.f_ready); end
        @(negedge clk);
        checks++; if (bus.depth !== 3'd0 || bus.f_ready !== 1'b1) begin errors++; $display("FAIL dret_done got depth=%0d ready=%0b want 0/1", bus.depth, bus.f_ready); end
        // decode ret+call alongside fetch ret predicts the decode push target
        idle(); fetch(0, 1, 32'h740);
        bus.d_valid = 1; bus.d_call = 1; bus.d_ret = 1; bus.d_pc = 32'h2220;
        #1;
        checks++; if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h2228 || bus.ras_pop_req !== 1'b0) begin errors++; $display("FAIL drepl got %0b/%h pop=%0b want 1/2228/0", bus.pred_valid, bus.pred_target, bus.ras_pop_req); end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_call_ret();
        test_underflow();
        test_decode_skid();
        test_saturate();
        test_flush_skid();
        test_wrap_and_replace();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
